// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic matmul core.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  // Accumulator must hold N full-precision products without wrapping.
  function automatic bit acc_w_ok(input int unsigned n, input int unsigned data_w,
                                  input int unsigned acc_w);
    return acc_w >= (2 * data_w + $clog2(n));
  endfunction

  // LSB position of element idx in a packed vector of elem_w-wide elements.
  function automatic int unsigned elem_lsb(input int unsigned idx, input int unsigned elem_w);
    return idx * elem_w;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One weight-stationary MAC cell: activation flows right, partial sum flows down.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_en,
  input  logic              i_w_load,
  input  logic [DATA_W-1:0] i_w,
  input  logic [DATA_W-1:0] i_a,
  input  logic [ACC_W-1:0]  i_psum,
  output logic [DATA_W-1:0] o_a,
  output logic [ACC_W-1:0]  o_psum
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  logic [DATA_W-1:0]        r_w;
  logic [DATA_W-1:0]        r_a;
  logic [ACC_W-1:0]         r_psum;
  logic signed [PROD_W-1:0] w_a_ext;
  logic signed [PROD_W-1:0] w_w_ext;
  logic signed [PROD_W-1:0] w_prod;
  logic [ACC_W-1:0]         w_prod_ext;

  assign w_a_ext    = {{DATA_W{i_a[DATA_W-1]}}, i_a};
  assign w_w_ext    = {{DATA_W{r_w[DATA_W-1]}}, r_w};
  assign w_prod     = w_a_ext * w_w_ext;
  assign w_prod_ext = {{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod};

  // Stationary weight, written only during the load phase.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_w <= '0;
    end else if (i_w_load) begin
      r_w <= i_w;
    end
  end

  // MAC stage; holds entirely when the array is stalled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_a    <= '0;
      r_psum <= '0;
    end else if (i_en) begin
      r_a    <= i_a;
      r_psum <= i_psum + w_prod_ext;
    end
  end

  assign o_a    = r_a;
  assign o_psum = r_psum;

endmodule

// File: rtl/systolic_core.sv
// N x N weight-stationary systolic matmul core with skew/deskew and valid/ready streams.
// Optional build macro SYSTOLIC_RELU_EN clamps negative results to zero in the output register.
module systolic_core
  import systolic_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CNT_W-1:0]    num_vec,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [N*DATA_W-1:0] w_row,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [N*DATA_W-1:0] a_vec,
  output logic                r_valid,
  input  logic                r_ready,
  output logic [N*ACC_W-1:0]  r_vec,
  output logic                busy,
  output logic                done
);

  localparam int unsigned ROW_W = $clog2(N);
  localparam int unsigned TAG_D = 2 * N - 1;

  if (!acc_w_ok(N, DATA_W, ACC_W)) begin : g_acc_w_chk
    $error("systolic_core: ACC_W too narrow for N and DATA_W");
  end

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_m;
  logic [CNT_W-1:0]   r_acc_cnt;
  logic [CNT_W-1:0]   r_res_cnt;
  logic [ROW_W-1:0]   r_row;
  logic               r_w_ready;
  logic               r_busy;
  logic               r_done;
  logic               r_r_valid;
  logic [N*ACC_W-1:0] r_r_vec;
  logic [TAG_D-1:0]   r_tag;
  logic               w_advance;
  logic               w_a_hs;
  logic               w_w_hs;
  logic               w_r_hs;
  logic [N-1:0]       w_w_load;
  logic [DATA_W-1:0]  w_arow [N];
  logic [DATA_W-1:0]  w_pe_a [N][N];
  logic [ACC_W-1:0]   w_pe_ps [N][N];
  logic [N*ACC_W-1:0] w_res;

  assign w_advance = !r_r_valid || r_ready;
  assign a_ready   = (r_state == STREAM) && w_advance && (r_acc_cnt < r_m);
  assign w_a_hs    = a_valid && a_ready;
  assign w_w_hs    = w_valid && r_w_ready;
  assign w_r_hs    = r_r_valid && r_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = LOAD_W;
      LOAD_W:  if (w_w_hs && (r_row == ROW_W'(N - 1))) w_next = STREAM;
      STREAM:  if (w_a_hs && (r_acc_cnt == r_m - CNT_W'(1))) w_next = DRAIN;
      DRAIN:   if (w_r_hs && (r_res_cnt == r_m - CNT_W'(1))) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Job counters and registered control outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_m       <= '0;
      r_acc_cnt <= '0;
      r_res_cnt <= '0;
      r_row     <= '0;
      r_w_ready <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_w_ready <= (w_next == LOAD_W);
      r_busy    <= (w_next != IDLE);
      r_done    <= (r_state == DRAIN) && (w_next == IDLE);
      if ((r_state == IDLE) && start) begin
        r_m       <= (num_vec == '0) ? CNT_W'(1) : num_vec;
        r_acc_cnt <= '0;
        r_res_cnt <= '0;
        r_row     <= '0;
      end else begin
        if (w_w_hs) r_row <= r_row + ROW_W'(1);
        if (w_a_hs) r_acc_cnt <= r_acc_cnt + CNT_W'(1);
        if (w_r_hs && ((r_state == STREAM) || (r_state == DRAIN)))
          r_res_cnt <= r_res_cnt + CNT_W'(1);
      end
    end
  end

  // Valid tag travels alongside the data through skew, array and deskew.
  always_ff @(posedge clk) begin
    if (!reset)         r_tag <= '0;
    else if (w_advance) r_tag <= {r_tag[TAG_D-2:0], w_a_hs};
  end

  // Input skew: array row i sees its activation i cycles late; bubbles inject zero.
  for (genvar i = 0; i < N; i++) begin : g_skew
    localparam int unsigned D = i;
    logic [DATA_W-1:0] w_inj;
    assign w_inj       = w_a_hs ? a_vec[elem_lsb(i, DATA_W) +: DATA_W] : '0;
    assign w_w_load[i] = w_w_hs && (r_row == ROW_W'(i));
    if (i == 0) begin : g_nodly
      assign w_arow[i] = w_inj;
    end else begin : g_dly
      logic [DATA_W-1:0] r_sk [D];
      // Skew delay line for this row.
      always_ff @(posedge clk) begin
        if (!reset) begin
          for (int k = 0; k < int'(D); k++) r_sk[k] <= '0;
        end else if (w_advance) begin
          r_sk[0] <= w_inj;
          for (int k = 1; k < int'(D); k++) r_sk[k] <= r_sk[k-1];
        end
      end
      assign w_arow[i] = r_sk[D-1];
    end
  end

  // PE grid.
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DATA_W-1:0] w_a_in;
      logic [ACC_W-1:0]  w_ps_in;
      if (j == 0) begin : g_a_edge
        assign w_a_in = w_arow[i];
      end else begin : g_a_mid
        assign w_a_in = w_pe_a[i][j-1];
      end
      if (i == 0) begin : g_ps_edge
        assign w_ps_in = '0;
      end else begin : g_ps_mid
        assign w_ps_in = w_pe_ps[i-1][j];
      end
      systolic_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk      (clk),
        .reset    (reset),
        .i_en     (w_advance),
        .i_w_load (w_w_load[i]),
        .i_w      (w_row[elem_lsb(j, DATA_W) +: DATA_W]),
        .i_a      (w_a_in),
        .i_psum   (w_ps_in),
        .o_a      (w_pe_a[i][j]),
        .o_psum   (w_pe_ps[i][j])
      );
    end
  end

  // Output deskew: column j waits N-1-j cycles so all columns line up.
  for (genvar j = 0; j < N; j++) begin : g_deskew
    localparam int unsigned D = N - 1 - j;
    logic [ACC_W-1:0] w_col;
    if (j == N - 1) begin : g_nodly
      assign w_col = w_pe_ps[N-1][j];
    end else begin : g_dly
      logic [ACC_W-1:0] r_ds [D];
      // Deskew delay line for this column.
      always_ff @(posedge clk) begin
        if (!reset) begin
          for (int k = 0; k < int'(D); k++) r_ds[k] <= '0;
        end else if (w_advance) begin
          r_ds[0] <= w_pe_ps[N-1][j];
          for (int k = 1; k < int'(D); k++) r_ds[k] <= r_ds[k-1];
        end
      end
      assign w_col = r_ds[D-1];
    end
`ifdef SYSTOLIC_RELU_EN
    assign w_res[elem_lsb(j, ACC_W) +: ACC_W] = w_col[ACC_W-1] ? '0 : w_col;
`else
    assign w_res[elem_lsb(j, ACC_W) +: ACC_W] = w_col;
`endif
  end

  // Result register; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_r_valid <= 1'b0;
      r_r_vec   <= '0;
    end else if (w_advance) begin
      r_r_valid <= r_tag[TAG_D-1];
      if (r_tag[TAG_D-1]) r_r_vec <= w_res;
    end
  end

  assign w_ready = r_w_ready;
  assign r_valid = r_r_valid;
  assign r_vec   = r_r_vec;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_systolic_core.sv
// Directed self-checking bench for systolic_core (N=4, DATA_W=8, ACC_W=24).
module tb_systolic_core;

  localparam int unsigned N      = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ACC_W  = 24;
  localparam int unsigned CNT_W  = 16;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                start = 1'b0;
  logic [CNT_W-1:0]    num_vec = '0;
  logic                w_valid = 1'b0;
  logic                w_ready;
  logic [N*DATA_W-1:0] w_row = '0;
  logic                a_valid = 1'b0;
  logic                a_ready;
  logic [N*DATA_W-1:0] a_vec = '0;
  logic                r_valid;
  logic                r_ready = 1'b0;
  logic [N*ACC_W-1:0]  r_vec;
  logic                busy;
  logic                done;

  systolic_core #(
    .N(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_vec(num_vec),
    .w_valid(w_valid), .w_ready(w_ready), .w_row(w_row),
    .a_valid(a_valid), .a_ready(a_ready), .a_vec(a_vec),
    .r_valid(r_valid), .r_ready(r_ready), .r_vec(r_vec),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [N*DATA_W-1:0] w_rows [N];
  logic [N*DATA_W-1:0] q_a [$];
  logic [N*ACC_W-1:0]  q_exp [$];

  task automatic chk(input string tag, input logic [N*ACC_W-1:0] obs,
                     input logic [N*ACC_W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*DATA_W-1:0] pk_a(input int e0, input int e1,
                                                input int e2, input int e3);
    logic [N*DATA_W-1:0] v;
    v = {DATA_W'(e3), DATA_W'(e2), DATA_W'(e1), DATA_W'(e0)};
    return v;
  endfunction

  function automatic logic [N*ACC_W-1:0] pk_r(input int e0, input int e1,
                                               input int e2, input int e3);
    logic [N*ACC_W-1:0] v;
    v = {ACC_W'(e3), ACC_W'(e2), ACC_W'(e1), ACC_W'(e0)};
    return v;
  endfunction

  // Plain matrix-vector reference against the currently staged weights.
  function automatic logic [N*ACC_W-1:0] model(input logic [N*DATA_W-1:0] av);
    logic [N*ACC_W-1:0] v;
    logic signed [DATA_W-1:0] ai, wij;
    int s;
    v = '0;
    for (int j = 0; j < int'(N); j++) begin
      s = 0;
      for (int i = 0; i < int'(N); i++) begin
        ai = av[i*DATA_W +: DATA_W];
        wij = w_rows[i][j*DATA_W +: DATA_W];
        s += int'(ai) * int'(wij);
      end
`ifdef SYSTOLIC_RELU_EN
      if (s < 0) s = 0;
`endif
      v[j*ACC_W +: ACC_W] = ACC_W'(s);
    end
    return v;
  endfunction

  task automatic load_job(input int m, input bit poke);
    start = 1'b1;
    num_vec = CNT_W'(m);
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("w_ready_in_load", w_ready, 1);
    for (int r = 0; r < int'(N); r++) begin
      w_valid = 1'b1;
      w_row = w_rows[r];
      if (poke && r == 1) begin
        start = 1'b1;
        num_vec = CNT_W'(9);
      end
      tick();
      start = 1'b0;
    end
    w_valid = 1'b0;
    w_row = '0;
    chk("w_ready_after_load", w_ready, 0);
  endtask

  // rr_mode 0: r_ready held high; 1: r_ready pattern 1,0,0,1.
  task automatic stream_job(input int rr_mode, input bit gaps, input bit chk_lat,
                            input bit poke);
    int sent, recv, cyc, m_exp;
    int acc_cyc [$];
    bit prev_stall, a_hs, r_hs;
    logic [N*ACC_W-1:0] prev_vec;
    sent = 0; recv = 0; cyc = 0; prev_stall = 1'b0; prev_vec = '0;
    m_exp = q_exp.size();
    while (recv < m_exp && cyc < 400) begin
      if (prev_stall) begin
        chk("stall_hold_valid", r_valid, 1);
        chk("stall_hold_vec", r_vec, prev_vec);
      end
      r_ready = (rr_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      a_valid = (sent < q_a.size()) && (!gaps || ($urandom_range(0, 2) != 0));
      a_vec = (sent < q_a.size()) ? q_a[sent] : '0;
      start = poke && (cyc == 3);
      #1;
      a_hs = a_valid && a_ready;
      r_hs = r_valid && r_ready;
      if (r_valid && !r_ready) chk("a_ready_while_stalled", a_ready, 0);
      if (r_hs) begin
        chk($sformatf("result%0d", recv), r_vec, q_exp[recv]);
        if (chk_lat) begin
          if (recv < acc_cyc.size()) chk("latency", cyc - acc_cyc[recv], 2 * N);
          else chk("result_before_accept", recv, acc_cyc.size());
        end
        recv++;
      end
      if (a_hs) begin
        acc_cyc.push_back(cyc);
        sent++;
      end
      prev_stall = r_valid && !r_ready;
      prev_vec = r_vec;
      @(posedge clk);
      #1;
      cyc++;
    end
    a_valid = 1'b0;
    start = 1'b0;
    r_ready = 1'b1;
    chk("results_received", recv, m_exp);
    chk("vectors_accepted", sent, m_exp);
    chk("done_pulse", done, 1);
    chk("busy_low_at_end", busy, 0);
    tick();
    chk("done_one_cycle", done, 0);
    chk("no_extra_result", r_valid, 0);
  endtask

  task automatic set_w_ident();
    for (int i = 0; i < int'(N); i++) begin
      w_rows[i] = '0;
      w_rows[i][i*DATA_W +: DATA_W] = DATA_W'(1);
    end
  endtask

  task automatic set_w_dense();
    for (int i = 0; i < int'(N); i++)
      for (int j = 0; j < int'(N); j++)
        w_rows[i][j*DATA_W +: DATA_W] = DATA_W'(i + j);
  endtask

  task automatic set_w_const(input int c);
    for (int i = 0; i < int'(N); i++)
      for (int j = 0; j < int'(N); j++)
        w_rows[i][j*DATA_W +: DATA_W] = DATA_W'(c);
  endtask

  initial begin
    int vcnt;

    // Reset state.
    reset = 1'b0;
    tick(); tick(); tick();
    chk("rst_w_ready", w_ready, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_r_vec", r_vec, '0);
    reset = 1'b1;
    tick();

    // Identity weights, three vectors, latency checked.
    set_w_ident();
    q_a.delete(); q_exp.delete();
    q_a.push_back(pk_a(1, 2, 3, 4));     q_exp.push_back(pk_r(1, 2, 3, 4));
    q_a.push_back(pk_a(5, 6, 7, 8));     q_exp.push_back(pk_r(5, 6, 7, 8));
    q_a.push_back(pk_a(-1, -2, -3, -4)); q_exp.push_back(pk_r(-1, -2, -3, -4));
    load_job(3, 1'b0);
    stream_job(0, 1'b0, 1'b1, 1'b0);

    // Dense weights W[i][j] = i + j.
    set_w_dense();
    q_a.delete(); q_exp.delete();
    q_a.push_back(pk_a(1, 1, 1, 1)); q_exp.push_back(pk_r(6, 10, 14, 18));
    load_job(1, 1'b0);
    stream_job(0, 1'b0, 1'b1, 1'b0);

    // Extremes: -128 * -128 summed over four rows.
    set_w_const(-128);
    q_a.delete(); q_exp.delete();
    q_a.push_back(pk_a(-128, -128, -128, -128));
    q_exp.push_back(pk_r(65536, 65536, 65536, 65536));
    load_job(1, 1'b0);
    stream_job(0, 1'b0, 1'b0, 1'b0);

    // Extremes with negative result: -128 * 127 summed over four rows.
    set_w_const(127);
    q_a.delete(); q_exp.delete();
    q_a.push_back(pk_a(-128, -128, -128, -128));
`ifdef SYSTOLIC_RELU_EN
    q_exp.push_back(pk_r(0, 0, 0, 0));
`else
    q_exp.push_back(pk_r(-65024, -65024, -65024, -65024));
`endif
    load_job(1, 1'b0);
    stream_job(0, 1'b0, 1'b0, 1'b0);

    // Backpressure with mixed-sign weights and random input gaps.
    for (int i = 0; i < int'(N); i++)
      for (int j = 0; j < int'(N); j++)
        w_rows[i][j*DATA_W +: DATA_W] = DATA_W'(i * 4 + j - 7);
    q_a.delete(); q_exp.delete();
    q_a.push_back(pk_a(1, -2, 3, -4));
    q_a.push_back(pk_a(10, 20, 30, 40));
    q_a.push_back(pk_a(-128, 127, 0, 1));
    q_a.push_back(pk_a(5, 5, 5, 5));
    q_a.push_back(pk_a(-7, 0, 7, 0));
    q_a.push_back(pk_a(100, -100, 50, -50));
    foreach (q_a[k]) q_exp.push_back(model(q_a[k]));
    load_job(6, 1'b0);
    stream_job(1, 1'b1, 1'b0, 1'b0);

    // Reset mid-job after two accepts.
    set_w_ident();
    load_job(4, 1'b0);
    r_ready = 1'b1;
    a_valid = 1'b1;
    a_vec = pk_a(9, 9, 9, 9);
    tick(); tick();
    reset = 1'b0;
    a_valid = 1'b0;
    tick();
    chk("midrst_w_ready", w_ready, 0);
    chk("midrst_a_ready", a_ready, 0);
    chk("midrst_r_valid", r_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_r_vec", r_vec, '0);
    reset = 1'b1;
    vcnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (r_valid) vcnt++;
      tick();
    end
    chk("no_result_after_abort", vcnt, 0);
    set_w_dense();
    q_a.delete(); q_exp.delete();
    q_a.push_back(pk_a(1, 1, 1, 1)); q_exp.push_back(pk_r(6, 10, 14, 18));
    q_a.push_back(pk_a(1, 0, 0, 0)); q_exp.push_back(pk_r(0, 1, 2, 3));
    load_job(2, 1'b0);
    stream_job(0, 1'b0, 1'b1, 1'b0);

    // num_vec = 0 behaves as one vector even with more offered.
    q_a.delete(); q_exp.delete();
    q_a.push_back(pk_a(2, 0, 0, 1)); q_exp.push_back(pk_r(3, 6, 9, 12));
    q_a.push_back(pk_a(7, 7, 7, 7));
    load_job(0, 1'b0);
    stream_job(0, 1'b0, 1'b0, 1'b0);

    // start pulsed during LOAD_W and STREAM is ignored.
    q_a.delete(); q_exp.delete();
    q_a.push_back(pk_a(1, 1, 1, 1));  q_exp.push_back(pk_r(6, 10, 14, 18));
    q_a.push_back(pk_a(0, 0, 0, -1)); q_exp.push_back(pk_r(-3, -4, -5, -6));
    q_a.push_back(pk_a(3, 0, 0, 0));  q_exp.push_back(pk_r(0, 3, 6, 9));
    q_a.push_back(pk_a(0, 2, 0, 0));  q_exp.push_back(pk_r(2, 4, 6, 8));
    q_a.push_back(pk_a(1, 2, 3, 4));  q_exp.push_back(pk_r(20, 30, 40, 50));
    load_job(5, 1'b1);
    stream_job(0, 1'b0, 1'b1, 1'b1);
    vcnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (busy) vcnt++;
      tick();
    end
    chk("stays_idle_after_ignored_start", vcnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
